// File: rtl/id_lifetime_tracker_pkg.sv
// Package for the ID lifetime tracker.
// Holds the in-flight counter update encoding and the helper that picks
// the update from this cycle's grant and legal-retire decisions.
package id_lifetime_tracker_pkg;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2
  } cnt_op_e;

  // A grant and a legal retire in the same cycle cancel out.
  function automatic cnt_op_e cnt_op_sel(input logic ack, input logic ret_ok);
    cnt_op_e op;
    op = CNT_HOLD;
    if (ack && !ret_ok) op = CNT_INC;
    else if (!ack && ret_ok) op = CNT_DEC;
    return op;
  endfunction

endpackage

// File: rtl/id_lifetime_tracker_toggle_flop_bank.sv
// toggle_flop_bank: DEPTH flop-based toggle bits.
// Ports:
//   clk_i, rst_ni   - clock, async active-low clear of all bits
//   tgl_en_i        - toggle the bit selected by tgl_idx_i at the edge
//   tgl_idx_i       - index of the bit to toggle
//   rd_idx_i[k]     - read-port indices
//   rd_data_o[k]    - combinational read of bits_q[rd_idx_i[k]]
//   bits_o          - full registered bit vector
module toggle_flop_bank
  import id_lifetime_tracker_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned NUM_READ_PORTS = 2,
  localparam int unsigned IDW           = $clog2(DEPTH)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      tgl_en_i,
  input  logic [IDW-1:0]            tgl_idx_i,
  input  logic [IDW-1:0]            rd_idx_i [NUM_READ_PORTS],
  output logic [NUM_READ_PORTS-1:0] rd_data_o,
  output logic [DEPTH-1:0]          bits_o
);

  logic [DEPTH-1:0] bits_q, bits_d;

  always_comb begin
    bits_d = bits_q;
    if (tgl_en_i) bits_d[tgl_idx_i] = ~bits_q[tgl_idx_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) bits_q <= '0;
    else         bits_q <= bits_d;
  end

  always_comb begin
    rd_data_o = '0;
    for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
      rd_data_o[k] = bits_q[rd_idx_i[k]];
    end
  end

  assign bits_o = bits_q;

endmodule

// File: rtl/id_lifetime_tracker.sv
// id_lifetime_tracker: round-robin transaction ID allocator with in-flight
// tracking. An ID is busy while its issue and retire toggle bits differ.
// Ports:
//   clk, rst_n       - clock, async active-low reset
//   alloc_req        - request an ID this cycle
//   alloc_ack        - grant (request and ID at alloc pointer free)
//   alloc_id         - granted ID (alloc pointer)
//   retire/retire_id - return an in-flight ID
//   query_id[k]      - IDs to query
//   query_busy[k]    - queried ID is in flight (registered state only)
//   inflight_count   - number of busy IDs
//   empty, full      - count == 0 / count == DEPTH
module id_lifetime_tracker
  import id_lifetime_tracker_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned NUM_READ_PORTS = 2,
  localparam int unsigned IDW           = $clog2(DEPTH),
  localparam int unsigned CNTW          = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alloc_req,
  output logic                      alloc_ack,
  output logic [IDW-1:0]            alloc_id,
  input  logic                      retire,
  input  logic [IDW-1:0]            retire_id,
  input  logic [IDW-1:0]            query_id [NUM_READ_PORTS],
  output logic [NUM_READ_PORTS-1:0] query_busy,
  output logic [CNTW-1:0]           inflight_count,
  output logic                      empty,
  output logic                      full
);

  logic [IDW-1:0]            alloc_ptr_q, alloc_ptr_d;
  logic [CNTW-1:0]           count_q, count_d;
  logic [DEPTH-1:0]          issue_bits, retire_bits, busy;
  logic [NUM_READ_PORTS-1:0] issue_rd, retire_rd;
  logic                      retire_ok;
  cnt_op_e                   cnt_op;

  toggle_flop_bank #(
    .DEPTH          (DEPTH),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_issue_bank (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tgl_en_i  (alloc_ack),
    .tgl_idx_i (alloc_ptr_q),
    .rd_idx_i  (query_id),
    .rd_data_o (issue_rd),
    .bits_o    (issue_bits)
  );

  toggle_flop_bank #(
    .DEPTH          (DEPTH),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_retire_bank (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .tgl_en_i  (retire_ok),
    .tgl_idx_i (retire_id),
    .rd_idx_i  (query_id),
    .rd_data_o (retire_rd),
    .bits_o    (retire_bits)
  );

  assign busy = issue_bits ^ retire_bits;

  // Head-of-line: only the ID at the pointer may be granted.
  assign alloc_ack = alloc_req & ~busy[alloc_ptr_q] & rst_n;
  assign alloc_id  = alloc_ptr_q;
  assign retire_ok = retire & busy[retire_id];

  // Per-port busy is the XOR of the two banks' read ports.
  assign query_busy = issue_rd ^ retire_rd;

  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    if (alloc_ack) alloc_ptr_d = alloc_ptr_q + IDW'(1);
  end

  always_comb begin
    cnt_op  = cnt_op_sel(alloc_ack, retire_ok);
    count_d = count_q;
    case (cnt_op)
      CNT_INC: count_d = count_q + CNTW'(1);
      CNT_DEC: count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_ptr_q <= '0;
      count_q     <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      count_q     <= count_d;
    end
  end

  assign inflight_count = count_q;
  assign empty          = (count_q == '0);
  assign full           = (count_q == CNTW'(DEPTH));

  // Returning an ID that is not in flight is a protocol error upstream;
  // the retire is dropped and flagged here.
  always_ff @(posedge clk) begin
    if (rst_n && retire) begin
      assert (busy[retire_id])
        else $warning("illegal retire of idle id %0d", retire_id);
    end
  end

endmodule
